// File: rtl/rv64_fetch.sv
// -----------------------------------------------------------------------------
// rv64_fetch -- RV64I instruction fetch stage
//
// Holds the fetch PC, issues word reads to an instruction memory with a fixed
// one-cycle read latency, and buffers returned words (with their PCs) in a
// small power-of-two FIFO consumed by decode through valid/ready. A redirect
// from execute reloads the PC and discards everything already fetched.
//
// Optional feature macro: RV64_FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect to a non word-aligned PC enqueues one fault marker
//               entry (out_fault = 1, out_pc = redirect_pc, out_instr = 0) and
//               fetch halts until the next redirect or reset.
//   undefined : redirect_pc[1:0] is forced to zero; out_fault is tied to 0.
//
// Parameters
//   RESET_PC    PC loaded at reset
//   FIFO_DEPTH  instruction buffer entries (power of two, >= 2)
//
// Ports
//   clk             single clock, rising edge
//   reset           synchronous, active-low reset
//   imem_req        read request this cycle
//   imem_addr       word address of the request (bits [1:0] always zero)
//   imem_rdata      instruction word, valid the cycle after a request
//   redirect_valid  PC redirect from execute
//   redirect_pc     new fetch PC
//   out_valid       FIFO head valid
//   out_ready       decode accepts the head
//   out_pc          PC of the head instruction
//   out_instr       head instruction word
//   out_fault       head is a misaligned-fetch fault marker
// -----------------------------------------------------------------------------
module rv64_fetch #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_fault
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Fetch PC and the single outstanding request
    logic [63:0]      r_pc;
    logic             r_inflight;
    logic [63:0]      r_inflight_pc;

    // Instruction buffer
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [63:0]      r_mem_pc    [FIFO_DEPTH];
    logic [31:0]      r_mem_instr [FIFO_DEPTH];

`ifdef RV64_FETCH_MISALIGN_TRAP_EN
    // Fault marker travels through the same one-cycle slot as a real fetch so
    // that it becomes visible with the same latency as a normal instruction.
    logic             r_mem_fault [FIFO_DEPTH];
    logic             r_inflight_fault;
    logic             r_fault_pend;
    logic             r_halt;
    logic             w_issue_fault;
`endif

    logic             w_pop;
    logic [CNT_W-1:0] w_occupancy;
    logic             w_credit_ok;
    logic             w_halted;
    logic             w_issue;
    logic [63:0]      w_redirect_target;

    // Credit check, issue decision and redirect target selection
    always_comb begin
        w_pop       = (r_count != {CNT_W{1'b0}}) & out_ready;
        // Occupancy never exceeds FIFO_DEPTH, and a pop implies count >= 1,
        // so neither the add nor the subtract can wrap.
        w_occupancy = r_count + CNT_W'(r_inflight);
        w_credit_ok = ((w_occupancy - CNT_W'(w_pop)) < DEPTH_C);
`ifdef RV64_FETCH_MISALIGN_TRAP_EN
        w_halted          = r_halt | r_fault_pend;
        w_issue_fault     = reset & ~redirect_valid & r_fault_pend & w_credit_ok;
        w_redirect_target = redirect_pc;
`else
        w_halted          = 1'b0;
        w_redirect_target = redirect_pc & 64'hFFFF_FFFF_FFFF_FFFC;
`endif
        w_issue = reset & ~redirect_valid & ~w_halted & w_credit_ok;
    end

    // Memory request port; the address is pinned to RESET_PC while in reset
    always_comb begin
        imem_req = w_issue;
        if (reset) begin
            imem_addr = r_pc;
        end else begin
            imem_addr = RESET_PC;
        end
    end

    // Decode-facing head entry, read straight from storage
    always_comb begin
        out_valid = (r_count != {CNT_W{1'b0}});
        out_pc    = r_mem_pc[r_rd_ptr];
        out_instr = r_mem_instr[r_rd_ptr];
`ifdef RV64_FETCH_MISALIGN_TRAP_EN
        out_fault = r_mem_fault[r_rd_ptr];
`else
        out_fault = 1'b0;
`endif
    end

    // PC, in-flight tracking and FIFO state; reset beats redirect beats normal flow
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 64'd0;
            r_count       <= {CNT_W{1'b0}};
            r_rd_ptr      <= {PTR_W{1'b0}};
            r_wr_ptr      <= {PTR_W{1'b0}};
            // Storage is cleared so the head reads as zero right after reset.
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem_pc[i]    <= 64'd0;
                r_mem_instr[i] <= 32'd0;
`ifdef RV64_FETCH_MISALIGN_TRAP_EN
                r_mem_fault[i] <= 1'b0;
`endif
            end
`ifdef RV64_FETCH_MISALIGN_TRAP_EN
            r_inflight_fault <= 1'b0;
            r_fault_pend     <= 1'b0;
            r_halt           <= 1'b0;
`endif
        end else if (redirect_valid) begin
            // Drop buffered entries, any pop, and the response arriving now.
            r_pc          <= w_redirect_target;
            r_inflight    <= 1'b0;
            r_inflight_pc <= r_inflight_pc;
            r_count       <= {CNT_W{1'b0}};
            r_rd_ptr      <= {PTR_W{1'b0}};
            r_wr_ptr      <= {PTR_W{1'b0}};
`ifdef RV64_FETCH_MISALIGN_TRAP_EN
            r_inflight_fault <= 1'b0;
            r_fault_pend     <= (redirect_pc[1:0] != 2'b00);
            r_halt           <= 1'b0;
`endif
        end else begin
            if (w_issue) begin
                r_pc <= r_pc + 64'd4;
            end else begin
                r_pc <= r_pc;
            end

            // One-cycle read latency: the slot is refilled or emptied every cycle.
`ifdef RV64_FETCH_MISALIGN_TRAP_EN
            r_inflight       <= w_issue | w_issue_fault;
            r_inflight_fault <= w_issue_fault;
            if (w_issue_fault) begin
                r_fault_pend <= 1'b0;
                r_halt       <= 1'b1;
            end else begin
                r_fault_pend <= r_fault_pend;
                r_halt       <= r_halt;
            end
`else
            r_inflight <= w_issue;
`endif
            r_inflight_pc <= r_pc;

            // Response write; credit accounting guarantees a free slot here.
            if (r_inflight) begin
                r_mem_pc[r_wr_ptr] <= r_inflight_pc;
`ifdef RV64_FETCH_MISALIGN_TRAP_EN
                r_mem_fault[r_wr_ptr] <= r_inflight_fault;
                if (r_inflight_fault) begin
                    r_mem_instr[r_wr_ptr] <= 32'd0;
                end else begin
                    r_mem_instr[r_wr_ptr] <= imem_rdata;
                end
`else
                r_mem_instr[r_wr_ptr] <= imem_rdata;
`endif
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end

            case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_rv64_fetch.sv
module tb_rv64_fetch;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam int          DEPTH  = 2;

    logic        clk;
    logic        rst_in;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;

    int checks = 0;
    int errors = 0;

    logic        last_req;
    logic [63:0] last_addr;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        logic        chk_head;
        logic [63:0] e_pc;
    } vec_t;

    vec_t vq[$];

    rv64_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (rst_in),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_fault      (out_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a distinct word per address
    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %b required %b", name, act, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Called at the negedge: remember the request, cross the edge, answer it
    task automatic clk_step();
        last_req  = imem_req;
        last_addr = imem_addr;
        @(posedge clk);
        #1;
        imem_rdata = (last_req === 1'b1) ? word_of(last_addr) : 32'hDEAD_BEEF;
    endtask

    task automatic drive(input logic r, input logic rv, input logic [63:0] rpc, input logic rdy);
        rst_in         = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
    endtask

    task automatic chk_head(input string tag, input logic [63:0] pc);
        chk1({tag, ".valid"}, out_valid, 1'b1);
        chk64({tag, ".pc"}, out_pc, pc);
        chk64({tag, ".instr"}, {32'd0, out_instr}, {32'd0, word_of(pc)});
        chk1({tag, ".fault"}, out_fault, 1'b0);
    endtask

    task automatic add(input logic r, input logic rdy, input logic req, input logic [63:0] addr,
                       input logic v, input logic ch, input logic [63:0] pc);
        vq.push_back('{r, rdy, req, addr, v, ch, pc});
    endtask

    // Redirect in cycle R, then watch R+1..R+4
    task automatic redirect_seq(input string tag, input logic [63:0] tgt,
                                input logic [63:0] eff, input logic rdy_r);
        drive(1'b1, 1'b1, tgt, rdy_r);
        @(negedge clk);
        chk1({tag, ".R.req"}, imem_req, 1'b0);
        clk_step();
        drive(1'b1, 1'b0, 64'd0, 1'b1);
        @(negedge clk);
        chk1({tag, ".R1.valid"}, out_valid, 1'b0);
        chk1({tag, ".R1.req"}, imem_req, 1'b1);
        chk64({tag, ".R1.addr"}, imem_addr, eff);
        clk_step();
        @(negedge clk);
        chk1({tag, ".R2.valid"}, out_valid, 1'b0);
        chk1({tag, ".R2.req"}, imem_req, 1'b1);
        chk64({tag, ".R2.addr"}, imem_addr, eff + 64'd4);
        clk_step();
        @(negedge clk);
        chk_head({tag, ".R3"}, eff);
        clk_step();
        @(negedge clk);
        chk_head({tag, ".R4"}, eff + 64'd4);
        clk_step();
    endtask

    initial begin : main
        logic [63:0] mq[$];
        int          minf;
        logic [63:0] minf_pc;
        logic [63:0] mpc;
        logic        r, rv, rdy, pop, mreq;
        logic [63:0] rpc;
        int          occ;

        imem_rdata = 32'hDEAD_BEEF;
        drive(1'b0, 1'b0, 64'd0, 1'b1);
        @(negedge clk);
        clk_step();

        // rst rdy | req addr | valid chk_head pc
        add(1'b0, 1'b1, 1'b0, 64'h1000, 1'b0, 1'b1, 64'h0);    // held in reset
        add(1'b1, 1'b1, 1'b1, 64'h1000, 1'b0, 1'b0, 64'h0);    // cycle 0
        add(1'b1, 1'b1, 1'b1, 64'h1004, 1'b0, 1'b0, 64'h0);    // cycle 1
        add(1'b1, 1'b1, 1'b1, 64'h1008, 1'b1, 1'b1, 64'h1000); // cycle 2: first out
        add(1'b1, 1'b0, 1'b0, 64'h0,    1'b1, 1'b1, 64'h1004); // stall: credit used
        add(1'b1, 1'b0, 1'b0, 64'h0,    1'b1, 1'b1, 64'h1004); // two buffered
        add(1'b0, 1'b0, 1'b0, 64'h1000, 1'b1, 1'b1, 64'h1004); // reset mid-stream
        add(1'b0, 1'b0, 1'b0, 64'h1000, 1'b0, 1'b1, 64'h0);    // next cycle: empty
        add(1'b1, 1'b0, 1'b1, 64'h1000, 1'b0, 1'b0, 64'h0);    // restart at RESET_PC
        add(1'b1, 1'b0, 1'b1, 64'h1004, 1'b0, 1'b0, 64'h0);
        add(1'b1, 1'b0, 1'b0, 64'h0,    1'b1, 1'b1, 64'h1000); // only 2 requests
        add(1'b1, 1'b0, 1'b0, 64'h0,    1'b1, 1'b1, 64'h1000);
        add(1'b1, 1'b1, 1'b1, 64'h1008, 1'b1, 1'b1, 64'h1000); // resume with pop
        add(1'b1, 1'b1, 1'b1, 64'h100C, 1'b1, 1'b1, 64'h1004);
        add(1'b1, 1'b1, 1'b1, 64'h1010, 1'b1, 1'b1, 64'h1008);

        foreach (vq[i]) begin
            drive(vq[i].rst, 1'b0, 64'd0, vq[i].rdy);
            @(negedge clk);
            chk1($sformatf("vec%0d.req", i), imem_req, vq[i].e_req);
            if (vq[i].e_req || !vq[i].rst)
                chk64($sformatf("vec%0d.addr", i), imem_addr, vq[i].e_addr);
            chk1($sformatf("vec%0d.valid", i), out_valid, vq[i].e_valid);
            if (vq[i].chk_head) begin
                chk64($sformatf("vec%0d.pc", i), out_pc, vq[i].e_pc);
                chk64($sformatf("vec%0d.instr", i), {32'd0, out_instr},
                      vq[i].e_valid ? {32'd0, word_of(vq[i].e_pc)} : 64'd0);
                chk1($sformatf("vec%0d.fault", i), out_fault, 1'b0);
            end
            clk_step();
        end

        // Redirect with buffer credit exhausted and a request in flight
        redirect_seq("redir_full", 64'h2000, 64'h2000, 1'b0);
        // Redirect coinciding with a pop and a response arrival
        redirect_seq("redir_pop", 64'h3000, 64'h3000, 1'b1);

`ifdef RV64_FETCH_MISALIGN_TRAP_EN
        drive(1'b1, 1'b1, 64'h2002, 1'b1);
        @(negedge clk);
        chk1("mis.R.req", imem_req, 1'b0);
        clk_step();
        drive(1'b1, 1'b0, 64'd0, 1'b1);
        @(negedge clk);
        chk1("mis.R1.req", imem_req, 1'b0);
        chk1("mis.R1.valid", out_valid, 1'b0);
        clk_step();
        @(negedge clk);
        chk1("mis.R2.req", imem_req, 1'b0);
        chk1("mis.R2.valid", out_valid, 1'b0);
        clk_step();
        @(negedge clk);
        chk1("mis.R3.valid", out_valid, 1'b1);
        chk1("mis.R3.fault", out_fault, 1'b1);
        chk64("mis.R3.pc", out_pc, 64'h2002);
        chk64("mis.R3.instr", {32'd0, out_instr}, 64'd0);
        chk1("mis.R3.req", imem_req, 1'b0);
        clk_step();
        @(negedge clk);
        chk1("mis.R4.valid", out_valid, 1'b0);
        chk1("mis.R4.req", imem_req, 1'b0);
        clk_step();
        drive(1'b1, 1'b1, 64'h3000, 1'b1);
        @(negedge clk);
        chk1("mis.R5.req", imem_req, 1'b0);
        clk_step();
        drive(1'b1, 1'b0, 64'd0, 1'b1);
        @(negedge clk);
        chk1("mis.R6.req", imem_req, 1'b1);
        chk64("mis.R6.addr", imem_addr, 64'h3000);
        clk_step();
`else
        redirect_seq("misalign", 64'h2002, 64'h2000, 1'b1);
`endif

        // Randomized run against a queue-level model
        drive(1'b0, 1'b0, 64'd0, 1'b1);
        @(negedge clk);
        clk_step();
        mq.delete();
        minf    = 0;
        minf_pc = 64'd0;
        mpc     = RST_PC;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r   = ($urandom_range(99) != 0);
            rv  = ($urandom_range(15) == 0);
            rpc = {$urandom, $urandom};
            if (($urandom_range(7) == 0)) rpc = 64'hFFFF_FFFF_FFFF_FFF8 | rpc[1:0];
`ifdef RV64_FETCH_MISALIGN_TRAP_EN
            rpc[1:0] = 2'b00;
`endif
            rdy = ($urandom_range(3) != 0);
            drive(r, rv, rpc, rdy);
            @(negedge clk);

            pop  = (mq.size() != 0) && rdy;
            occ  = mq.size() + minf - (pop ? 1 : 0);
            mreq = r && !rv && (occ < DEPTH);

            chk1("rnd.valid", out_valid, (mq.size() != 0));
            if (mq.size() != 0) begin
                chk64("rnd.pc", out_pc, mq[0]);
                chk64("rnd.instr", {32'd0, out_instr}, {32'd0, word_of(mq[0])});
            end
            chk1("rnd.fault", out_fault, 1'b0);
            chk1("rnd.req", imem_req, mreq);
            if (mreq) chk64("rnd.addr", imem_addr, mpc);
            if (!r) chk64("rnd.rst_addr", imem_addr, RST_PC);
            clk_step();

            if (!r) begin
                mq.delete();
                minf = 0;
                mpc  = RST_PC;
            end else if (rv) begin
                mq.delete();
                minf = 0;
                mpc  = rpc & ~64'h3;
            end else begin
                if (pop) mq.delete(0);
                if (minf != 0) mq.push_back(minf_pc);
                minf    = mreq ? 1 : 0;
                minf_pc = mpc;
                if (mreq) mpc = mpc + 64'd4;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv64_fetch.md
# rv64_fetch

Instruction fetch stage for the RV64I core. Holds the program counter, issues word reads to instruction memory (fixed one-cycle read latency) and buffers returned instructions in a small FIFO. Decode consumes the FIFO through a valid/ready handshake. A redirect port lets execute steer the PC on taken branches and jumps, and flushes all stale fetches.

## Interface
- `RESET_PC`, default 64'h0: PC loaded at reset.
- `FIFO_DEPTH`, default 2: instruction buffer entries, power of two, ≥ 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low; sampled on `clk`.
- `imem_req` output 1: read request this cycle.
- `imem_addr` output 64: word address of the request; bits [1:0] are always 0.
- `imem_rdata` input 32: instruction word, valid in the cycle after an accepted `imem_req`.
- `redirect_valid` input 1: PC redirect from execute.
- `redirect_pc` input 64: new fetch PC.
- `out_valid` output 1: FIFO head valid.
- `out_ready` input 1: decode accepts the head.
- `out_pc` output 64: PC of the head instruction.
- `out_instr` output 32: head instruction word.
- `out_fault` output 1: head is a misaligned-fetch fault marker (feature-gated).

## Operation
- State:
  - `pc`: next address to request.
  - `inflight`: 0/1 request awaiting response, with its tagged PC.
  - FIFO: `count`, read pointer and write pointer, each pointer with `log2(FIFO_DEPTH)` bits and wrapping modulo `FIFO_DEPTH`.
- Issue rule: `imem_req` = 1 iff all of the following hold:
  - not in reset;
  - `redirect_valid` = 0;
  - not halted (see Configuration);
  - `count + inflight - pop < FIFO_DEPTH`, where pop = `out_valid & out_ready`.
- On issue: `imem_addr` = `pc`, `pc` ← `pc + 4` (64-bit wrap), `inflight` ← 1.
- Response: in the cycle after an issue, `imem_rdata` and the tagged PC are written at the write pointer, `count` +1. The credit rule guarantees the FIFO is never full on a write.
- Pop: when `out_valid & out_ready`, the read pointer advances and `count` decrements. A simultaneous write and pop leaves `count` unchanged.
- `out_valid` = (`count` ≠ 0). `out_pc`, `out_instr` and `out_fault` come directly from the head entry, with no combinational path from `imem_rdata`.
- Redirect, when `redirect_valid` = 1:
  - `count` ← 0 and both pointers ← 0;
  - any response arriving this cycle is discarded;
  - `inflight` ← 0;
  - `pc` ← `redirect_pc`;
  - any pop this cycle is ignored (redirect wins).
- Reset (active-low, synchronous, also when asserted mid-operation):
  - `pc` ← `RESET_PC`, `count` ← 0, pointers ← 0, `inflight` ← 0, halt ← 0;
  - outputs during reset and in the first cycle after it: `imem_req` = 0, `imem_addr` = `RESET_PC`, `out_valid` = 0, `out_pc` = 0, `out_instr` = 0, `out_fault` = 0.

## Timing
- First request: `imem_req` = 1 with `imem_addr` = `RESET_PC` in the first cycle with `reset` high (call it cycle 0).
- Fetch latency: request in cycle N → FIFO write at the end of N+1 → `out_valid` in N+2.
- Throughput: 1 instruction per cycle sustained while `out_ready` stays high.
- Redirect in cycle R:
  - `imem_req` = 0 in R;
  - request for `redirect_pc` in R+1;
  - `out_valid` = 0 in R+1 and R+2;
  - first new instruction visible in R+3.
- Backpressure with `out_ready` held low: issue stops once `count + inflight` reaches `FIFO_DEPTH`, and resumes in the cycle in which a pop occurs.

## Configuration
- Macro: `RV64_FETCH_MISALIGN_TRAP_EN`.
- Defined:
  - a redirect with `redirect_pc[1:0]` ≠ 0 issues no request and enqueues one entry with `out_fault` = 1, `out_pc` = `redirect_pc` and `out_instr` = 0;
  - fetch then halts (no further `imem_req`) until the next redirect or reset.
- Undefined:
  - `redirect_pc[1:0]` is forced to 0, and fetch continues normally from the aligned address;
  - `out_fault` is tied to 0 and the halt state does not exist.

## Test plan
- Reset release with `RESET_PC` = 0x1000 and `out_ready` = 1 → requests to 0x1000, 0x1004, 0x1008 in cycles 0, 1, 2; `out_valid` first high in cycle 2 with `out_pc` = 0x1000 and `out_instr` = word returned for 0x1000.
- `out_ready` held low from reset → exactly 2 requests issued (0x1000, 0x1004) and then `imem_req` = 0; raising `out_ready` → next request (0x1008) issued in the same cycle as the first pop.
- Redirect to 0x2000 while the FIFO is full and a request is in flight → `out_valid` = 0 for two cycles; next delivered `out_pc` = 0x2000; no 0x10xx entry ever reaches decode.
- Redirect in the same cycle as a pop and a response arrival → `count` = 0 afterwards; the popped and arriving entries are both dropped, and decode sees no duplicate or stale entry.
- With the macro defined: redirect to 0x2002 → one entry with `out_fault` = 1 and `out_pc` = 0x2002, then no `imem_req`; a following redirect to 0x3000 resumes fetch. With the macro undefined: redirect to 0x2002 → fetch from 0x2000.
- `reset` driven low mid-stream with 2 entries buffered → next cycle `out_valid` = 0 and `imem_req` = 0; after release, fetch restarts at `RESET_PC`.
